uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Serial transmit stage of the FullUART datapath. Sits directly downstream of the transmit-holding load register and consumes its 8-bit output. On a start strobe it captures the byte and drives one asynchronous serial frame on the tx line: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It signals ready/done back to the control logic that strobes the load register.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535
CNT_W, 16, width of the bit-timer counter; must hold CLKS_PER_BIT-1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
tx_start  input  1  request to send; sampled only while idle
tx_data  input  8  byte to send, driven by the load register output
par_en  input  1  1 = append parity bit
par_odd  input  1  1 = odd parity, 0 = even parity
two_stop  input  1  1 = two stop bits, 0 = one stop bit
tx  output  1  serial line, registered, idle high
tx_rdy  output  1  high while idle and able to accept tx_start
tx_done  output  1  one-cycle pulse at end of the final stop bit

Behaviour:
- Reset (async): state=IDLE, tx=1, tx_rdy=1, tx_done=0, bit timer=0, bit index=0, shift reg=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_rdy=1. If tx_start=1 on a clock edge:
  - capture tx_data into the shift register;
  - capture par_en, par_odd and two_stop into frame-config registers;
  - compute the parity bit: ^tx_data for even, ~^tx_data for odd;
  - go to START with tx_rdy=0.
- Latency: tx falls on the first edge after tx_start is sampled (single registered stage).
- Bit timing: timer counts 0..CLKS_PER_BIT-1. Each bit holds tx for exactly CLKS_PER_BIT cycles. The state or bit advances when timer = CLKS_PER_BIT-1, and the timer then wraps to 0.
- START: tx=0 for one bit, then go to DATA with bit index=0.
- DATA: tx = shift[0]; shift right at each bit end. After bit index 7, go to PARITY if par_en, else go to STOP.
- PARITY: tx = captured parity bit for one bit, then go to STOP.
- STOP: tx=1 for one bit, or for two bits if two_stop. Then return to IDLE.
- tx_done is asserted for exactly one cycle, the first IDLE cycle. tx_rdy is also 1 in that cycle.
- Frame length in cycles: CLKS_PER_BIT × (10 + par_en + two_stop).
- tx_start while tx_rdy=0: ignored. No queueing and no effect on the frame in progress.
- tx_start in the tx_done cycle: accepted, giving back-to-back frames with zero idle gap (the stop bit is immediately followed by a start bit).
- Changes on tx_data and the config inputs mid-frame have no effect, because all are captured at accept.
- Reset mid-frame: tx returns to 1 immediately (async) and the frame is aborted. No tx_done pulse is emitted.
- tx is driven only from a flop, never decoded combinationally.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding (3-bit localparams IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - DATA_BITS=8;
  - default CLKS_PER_BIT.
- One natural sub-module: uart_bit_timer.
  - Parameterized CLKS_PER_BIT.
  - Inputs: clk, rst, clr.
  - Output: bit_end pulse.
  - Shared later with the receive engine (half-bit sampling added there).

Test Plan:
- Bench uses CLKS_PER_BIT=4.
- Reset idle: assert rst for 3 cycles, release → tx=1, tx_rdy=1, tx_done=0; hold for 20 cycles with no change.
- Basic frame: tx_data=8'hA5, par_en=0, two_stop=0, pulse tx_start → tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. tx_done pulses at cycle 41 after accept; tx_rdy is low for 40 cycles.
- Parity and two stop bits: tx_data=8'h07, par_en=1, par_odd=0, two_stop=1 → parity bit=1, frame=0,1,1,1,0,0,0,0,0,1,1,1 (48 cycles). Repeat with par_odd=1 → parity bit=0.
- Busy/back-to-back:
  - Pulse tx_start mid-frame with tx_data=8'hFF → ignored; the current byte 8'h3C completes unchanged.
  - Then hold tx_start high through the tx_done cycle with 8'h81 → the next start bit begins on the following edge with no idle bit.
- Reset mid-frame: assert rst during data bit 3 of 8'h55 → tx=1 and tx_rdy=1 asynchronously, no tx_done pulse. A new frame after release is bit-exact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit/receive engines: state encoding,
// frame constants and the parity helper.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Even parity makes the total count of ones (data + parity) even.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                         input logic                 odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_end
// on the last count. Held at zero while clr is high.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    assign bit_end = !clr && (count_reg == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr || bit_end) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: captures a byte and its frame configuration on
// tx_start and shifts out start, 8 data bits LSB first, optional parity, 1/2 stops.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       par_en,
    input  logic       par_odd,
    input  logic       two_stop,
    output logic       tx,
    output logic       tx_rdy,
    output logic       tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_t          state_reg, state_next;
    logic                 tx_reg, tx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic                 stop_cnt_reg, stop_cnt_next;
    logic                 par_bit_reg, par_bit_next;
    logic                 par_en_reg, par_en_next;
    logic                 two_stop_reg, two_stop_next;
    logic                 done_reg, done_next;
    logic                 bit_end;

    // The timer is held at zero while idle so every frame starts on a fresh bit period.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (state_reg == IDLE),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            tx_reg       <= 1'b1;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            par_bit_reg  <= 1'b0;
            par_en_reg   <= 1'b0;
            two_stop_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_reg       <= tx_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            stop_cnt_reg <= stop_cnt_next;
            par_bit_reg  <= par_bit_next;
            par_en_reg   <= par_en_next;
            two_stop_reg <= two_stop_next;
            done_reg     <= done_next;
        end
    end

    // tx_next always carries the level of the bit being entered, so tx stays a pure flop.
    always_comb begin
        state_next    = state_reg;
        tx_next       = tx_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        stop_cnt_next = stop_cnt_reg;
        par_bit_next  = par_bit_reg;
        par_en_next   = par_en_reg;
        two_stop_next = two_stop_reg;
        done_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    shift_next    = tx_data;
                    par_en_next   = par_en;
                    two_stop_next = two_stop;
                    par_bit_next  = calc_parity(tx_data, par_odd);
                    bit_idx_next  = '0;
                    stop_cnt_next = 1'b0;
                    tx_next       = 1'b0;
                    state_next    = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_idx_reg == LAST_BIT) begin
                        if (par_en_reg) begin
                            tx_next    = par_bit_reg;
                            state_next = PARITY;
                        end else begin
                            tx_next    = 1'b1;
                            state_next = STOP;
                        end
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    tx_next    = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_stop_reg && !stop_cnt_reg) begin
                        stop_cnt_next = 1'b1;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    assign tx      = tx_reg;
    assign tx_rdy  = (state_reg == IDLE);
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed frame table, busy/back-to-back
// and mid-frame reset sequences, then random frames against a frame-builder model.
module tb_uart_tx_engine;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       tx;
    logic       tx_rdy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    uart_tx_engine #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .par_en  (par_en),
        .par_odd (par_odd),
        .two_stop(two_stop),
        .tx      (tx),
        .tx_rdy  (tx_rdy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        pe;
        logic        po;
        logic        ts;
        logic [11:0] frame;   // bit i = i-th bit on the line
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: build the line sequence straight from the frame rules.
    function automatic logic [11:0] model_bits(input logic [7:0] d, input logic pe,
                                               input logic po, input logic ts);
        bit          q[$];
        logic [11:0] v;
        v = '1;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (pe) q.push_back((($countones(d) % 2) == 1) ^ po);
        q.push_back(1'b1);
        if (ts) q.push_back(1'b1);
        for (int i = 0; i < q.size(); i++) v[i] = q[i];
        return v;
    endfunction

    // Call at a negedge while idle (or in the done cycle); returns in cycle 1 of the frame.
    task automatic start_frame(input logic [7:0] d, input logic pe, input logic po,
                               input logic ts);
        tx_data  = d;
        par_en   = pe;
        par_odd  = po;
        two_stop = ts;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Checks every busy cycle, then the done cycle; returns sampling the done cycle.
    task automatic check_frame(input logic [11:0] bits, input int nbits, input bit garble);
        for (int c = 0; c < nbits * CPB; c++) begin
            chk("tx_bit", tx, bits[c / CPB]);
            chk("rdy_busy", tx_rdy, 1'b0);
            chk("done_busy", tx_done, 1'b0);
            if (garble) begin
                tx_data  = 8'($urandom);
                par_en   = 1'($urandom);
                par_odd  = 1'($urandom);
                two_stop = 1'($urandom);
                tx_start = 1'($urandom);
            end
            @(negedge clk);
        end
        tx_start = 1'b0;
        chk("done_pulse", tx_done, 1'b1);
        chk("rdy_done", tx_rdy, 1'b1);
        chk("tx_done_idle", tx, 1'b1);
    endtask

    task automatic end_frame();
        @(negedge clk);
        chk("done_once", tx_done, 1'b0);
        chk("rdy_idle", tx_rdy, 1'b1);
        chk("tx_idle", tx, 1'b1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 12'({1'b1, 8'hA5, 1'b0}), 10};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 12'({2'b11, 1'b1, 8'h07, 1'b0}), 12};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b1, 12'({2'b11, 1'b0, 8'h07, 1'b0}), 12};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b0, 12'({1'b1, 1'b1, 8'h00, 1'b0}), 11};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 12'({1'b1, 1'b0, 8'hFF, 1'b0}), 11};
        vecs[5] = '{8'hC3, 1'b0, 1'b0, 1'b1, 12'({2'b11, 8'hC3, 1'b0}), 11};

        // Reset and quiet idle
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", tx, 1'b1);
            chk("rst_rdy", tx_rdy, 1'b1);
            chk("rst_done", tx_done, 1'b0);
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            chk("idle_tx", tx, 1'b1);
            chk("idle_rdy", tx_rdy, 1'b1);
            chk("idle_done", tx_done, 1'b0);
        end

        // Directed frame table
        for (int i = 0; i < 6; i++) begin
            $display("vector %0d: data=%h par_en=%b par_odd=%b two_stop=%b bits=%0d",
                     i, vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].ts, vecs[i].nbits);
            start_frame(vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].ts);
            check_frame(vecs[i].frame, vecs[i].nbits, 1'b0);
            end_frame();
        end

        // Busy: inputs churn and tx_start pulses mid-frame, then 8'h81 chained in the done cycle
        $display("busy: data=3c with mid-frame churn, then back-to-back data=81");
        start_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        tx_data  = 8'hFF;
        tx_start = 1'b1;
        check_frame(12'({1'b1, 8'h3C, 1'b0}), 10, 1'b1);
        start_frame(8'h81, 1'b0, 1'b0, 1'b0);
        check_frame(12'({1'b1, 8'h81, 1'b0}), 10, 1'b0);
        end_frame();

        // Reset during data bit 3 of 8'h55
        $display("reset mid-frame: data=55 aborted in data bit 3");
        start_frame(8'h55, 1'b0, 1'b0, 1'b0);
        repeat (17) @(negedge clk);
        chk("mid_tx_d3", tx, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("arst_tx", tx, 1'b1);
        chk("arst_rdy", tx_rdy, 1'b1);
        chk("arst_done", tx_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_tx", tx, 1'b1);
            chk("post_rst_rdy", tx_rdy, 1'b1);
            chk("post_rst_done", tx_done, 1'b0);
        end
        $display("after reset: data=55 par_en=1 par_odd=1 two_stop=1");
        start_frame(8'h55, 1'b1, 1'b1, 1'b1);
        check_frame(12'({2'b11, 1'b1, 8'h55, 1'b0}), 12, 1'b0);
        end_frame();

        // Random frames against the model, some chained back-to-back
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       pe, po, ts;
            bit         garble;
            d      = 8'($urandom);
            pe     = 1'($urandom);
            po     = 1'($urandom);
            ts     = 1'($urandom);
            garble = 1'($urandom);
            $display("random %0d: data=%h par_en=%b par_odd=%b two_stop=%b churn=%0d",
                     i, d, pe, po, ts, garble);
            start_frame(d, pe, po, ts);
            check_frame(model_bits(d, pe, po, ts), 10 + int'(pe) + int'(ts), garble);
            if (i == 23 || $urandom_range(0, 1) == 0) end_frame();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
